// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM bus master: bus widths, FSM states, request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_bus_pkg;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2,
      VERIFY  = 2'd3
   } state_t;

   // Request as captured at acceptance; held unchanged for the whole access.
   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Counter value on the final chip-select-low cycle of an access lasting 'cycles'.
   function automatic logic [CNT_W-1:0] last_count(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/sram_bus_master.sv
// Single-outstanding load/store master driving the 32-bit SRAM wrapper bus (optional feature macro: SRAM_MASTER_VERIFY_EN).
// Latency: resp_valid N+1 cycles after acceptance (N = READ_CYCLES/WRITE_CYCLES); WRITE+READ+3 for verified stores.
// Backpressure: req_ready is high only in IDLE; req_valid is ignored while an access or recovery cycle is in progress.
module sram_bus_master
   import sram_bus_pkg::*;
#(
   parameter int READ_CYCLES  = 4,
   parameter int WRITE_CYCLES = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   inout  wire  [DATA_W-1:0] bus_data,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_cs_n,
   output logic              bus_write
);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   req_t              req_q, req_nxt;
   logic              verify_q, verify_nxt;   // current access is the read-back of a store
   logic              drive_en, drive_en_nxt;
   logic              req_ready_nxt;
   logic              bus_cs_n_nxt;
   logic              bus_write_nxt;
   logic [ADDR_W-1:0] bus_addr_nxt;
   logic              resp_valid_nxt;
   logic [DATA_W-1:0] resp_rdata_nxt;
   logic              write_phase;
   logic              access_last;
   logic              store_pending_verify;

`ifdef SRAM_MASTER_VERIFY_EN
   logic              err_q, err_nxt;
`endif

   // A verify pass is a read even though the latched request is a store.
   assign write_phase = req_q.write & ~verify_q;
   assign access_last = write_phase ? (cnt == last_count(WRITE_CYCLES))
                                    : (cnt == last_count(READ_CYCLES));

   // Next-state, datapath and next-output decode; outputs are derived from the next state so they can be registered.
   always_comb begin
      state_nxt            = state;
      cnt_nxt              = cnt;
      req_nxt              = req_q;
      verify_nxt           = verify_q;
      resp_rdata_nxt       = resp_rdata;
      store_pending_verify = 1'b0;
`ifdef SRAM_MASTER_VERIFY_EN
      err_nxt              = err_q;
`endif

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               req_nxt    = '{write: req_write, addr: req_addr, wdata: req_wdata};
               cnt_nxt    = '0;
               verify_nxt = 1'b0;
               state_nxt  = ACCESS;
            end
         end
         ACCESS: begin
            cnt_nxt = cnt + 1'b1;
            if (access_last) begin
               state_nxt = RECOVER;
`ifdef SRAM_MASTER_VERIFY_EN
               err_nxt = verify_q ? (bus_data != req_q.wdata) : 1'b0;
`endif
               if (!req_q.write) begin
                  resp_rdata_nxt = bus_data;
               end
            end
         end
         RECOVER: begin
            state_nxt = IDLE;
`ifdef SRAM_MASTER_VERIFY_EN
            if (req_q.write && !verify_q) begin
               state_nxt = VERIFY;
            end
`endif
         end
         VERIFY: begin
            // One idle chip-select cycle, then re-enter ACCESS as a read.
            verify_nxt = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = ACCESS;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

`ifdef SRAM_MASTER_VERIFY_EN
      store_pending_verify = req_nxt.write && !verify_nxt;
`endif

      req_ready_nxt  = (state_nxt == IDLE);
      bus_cs_n_nxt   = (state_nxt != ACCESS);
      bus_write_nxt  = (state_nxt == ACCESS) && req_nxt.write && !verify_nxt;
      drive_en_nxt   = bus_write_nxt;
      bus_addr_nxt   = (state_nxt == ACCESS) ? req_nxt.addr : bus_addr;
      resp_valid_nxt = (state_nxt == RECOVER) && !store_pending_verify;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request latch, cycle counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         req_q      <= '0;
         verify_q   <= 1'b0;
         drive_en   <= 1'b0;
         req_ready  <= 1'b1;
         bus_cs_n   <= 1'b1;
         bus_write  <= 1'b0;
         bus_addr   <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         cnt        <= cnt_nxt;
         req_q      <= req_nxt;
         verify_q   <= verify_nxt;
         drive_en   <= drive_en_nxt;
         req_ready  <= req_ready_nxt;
         bus_cs_n   <= bus_cs_n_nxt;
         bus_write  <= bus_write_nxt;
         bus_addr   <= bus_addr_nxt;
         resp_valid <= resp_valid_nxt;
         resp_rdata <= resp_rdata_nxt;
      end
   end

`ifdef SRAM_MASTER_VERIFY_EN
   // Write-verify result, presented alongside the verify response.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_nxt;
      end
   end

   assign resp_err = err_q;
`else
   assign resp_err = 1'b0;
`endif

   // Drive enable is a registered bit mirroring bus_write, so the master never drives while the wrapper does.
   assign bus_data = drive_en ? req_q.wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_bus_master.sv
// Randomized scoreboard bench for sram_bus_master with a behavioural SRAM wrapper model.
// Latency: checks response and ready timing against the access-length rules.
// Backpressure: driver holds req_valid until req_ready, optionally keeping it high back-to-back.
module tb_sram_bus_master;
   import sram_bus_pkg::*;

   localparam int RC = 4;
   localparam int WC = 5;
`ifdef SRAM_MASTER_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [10:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   tri   [31:0] bus_data;
   logic [10:0] bus_addr;
   logic        bus_cs_n, bus_write;

   always #5 clk = ~clk;

   sram_bus_master #(.READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .bus_data(bus_data), .bus_addr(bus_addr), .bus_cs_n(bus_cs_n), .bus_write(bus_write)
   );

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
   endfunction

   // SRAM wrapper model: drives the bus on reads, captures on writes; corrupt flips bit 0 of read data.
   logic [31:0] sram_mem [0:2047];
   logic        mem_init;
   logic        corrupt;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 2048; i++) sram_mem[i] <= init_word(i);
      end else if (!bus_cs_n && bus_write) begin
         sram_mem[bus_addr] <= bus_data;
      end
   end
   assign bus_data = (!bus_cs_n && !bus_write) ? (sram_mem[bus_addr] ^ {31'd0, corrupt}) : 32'bz;

   // Reference model and scoreboard.
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [10:0] addr;
      logic        wr;
      int          lat;
      int          c0;
   } exp_t;

   logic [31:0] ref_mem [0:2047];
   logic [31:0] last_rdata;
   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          cs_len = 0;
   int          burst = 0;
   bit          mon_quiet = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: checks bus behaviour per cycle and pops the scoreboard on each response.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_quiet || reset) begin
            cs_len = 0;
            burst  = 0;
         end else if (!bus_cs_n) begin
            cs_len++;
            if (sb.size() == 0) begin
               check("cs_low_with_no_request", 32'(sb.size()), 32'd1);
            end else begin
               check("bus_addr", 32'(bus_addr), 32'(sb[0].addr));
               check("bus_write", 32'(bus_write), (burst == 0) ? 32'(sb[0].wr) : 32'd0);
            end
         end else if (cs_len > 0) begin
            if (sb.size() != 0)
               check("cs_low_cycles", 32'(cs_len), (burst == 0 && sb[0].wr) ? 32'(WC) : 32'(RC));
            burst++;
            cs_len = 0;
         end
         if (resp_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_resp", 32'(sb.size()), 32'd1);
            end else begin
               mon_e = sb.pop_front();
               check("resp_rdata", resp_rdata, mon_e.rdata);
               check("resp_err", 32'(resp_err), 32'(mon_e.err));
               check("resp_latency", 32'(cyc - mon_e.c0), 32'(mon_e.lat));
               check("access_count", 32'(burst), (mon_e.wr && VER) ? 32'd2 : 32'd1);
            end
            burst = 0;
         end
      end
   end

   // Present one request, record its expectation at acceptance, and wait for the master to return to IDLE.
   task automatic issue(input bit wr, input logic [10:0] a, input logic [31:0] d,
                        input bit keep, input bit glitch);
      exp_t e;
      int   w;
      int   rl;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      w = 0;
      while (!req_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("accept_before_timeout", 32'(req_ready), 32'd1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      e.addr = a;
      e.wr   = wr;
      e.c0   = cyc;
      if (wr) begin
         e.rdata    = last_rdata;
         e.err      = VER && corrupt;
         e.lat      = VER ? (WC + RC + 3) : (WC + 1);
         ref_mem[a] = d;
         rl         = VER ? (WC + RC + 4) : (WC + 2);
      end else begin
         e.rdata    = ref_mem[a];
         e.err      = 1'b0;
         e.lat      = RC + 1;
         last_rdata = ref_mem[a];
         rl         = RC + 2;
      end
      sb.push_back(e);
      @(negedge clk);
      if (!keep) begin
         // Request fields change after acceptance; the access must not notice.
         req_valid = 1'b0;
         req_write = 1'($urandom);
         req_addr  = 11'($urandom);
         req_wdata = $urandom;
      end
      if (glitch && !keep) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_write = ~wr;
         req_addr  = a ^ 11'h2AA;
         @(negedge clk);
         req_valid = 1'b0;
      end
      w = 0;
      while (!req_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("ready_latency", 32'(cyc - e.c0), 32'(rl));
      if (!keep) req_valid = 1'b0;
   endtask

   // Store aborted by reset in its second access cycle: no response, bus idle afterwards.
   task automatic reset_abort();
      logic [10:0] a;
      a = 11'h3AA;
      mon_quiet = 1'b1;
      req_write = 1'b1;
      req_addr  = a;
      req_wdata = ref_mem[a];   // same contents, so the partial write leaves memory unchanged
      req_valid = 1'b1;
      check("abort_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_cs_active", 32'(bus_cs_n), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_cs_n", 32'(bus_cs_n), 32'd1);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_bus_write", 32'(bus_write), 32'd0);
      check("abort_rdata", resp_rdata, 32'd0);
      repeat (8) begin
         @(negedge clk);
         check("abort_no_resp", 32'(resp_valid), 32'd0);
         check("abort_cs_idle", 32'(bus_cs_n), 32'd1);
      end
      last_rdata = 32'd0;
      mon_quiet  = 1'b0;
   endtask

   // Main sequence.
   initial begin
      logic [10:0] a;
      bit          wr, keep, glitch;
      int          w;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      mem_init   = 1'b1;
      corrupt    = 1'b0;
      last_rdata = '0;
      for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_cs_n", 32'(bus_cs_n), 32'd1);
      check("rst_bus_write", 32'(bus_write), 32'd0);
      check("rst_bus_addr", 32'(bus_addr), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);

      issue(1'b1, 11'h005, 32'h12345678, 1'b0, 1'b0);
      issue(1'b0, 11'h005, 32'h0, 1'b0, 1'b0);
      issue(1'b0, 11'h7FF, 32'h0, 1'b1, 1'b0);
      issue(1'b0, 11'h7FF, 32'h0, 1'b0, 1'b0);
      issue(1'b1, 11'h000, 32'hFFFFFFFF, 1'b0, 1'b1);
      issue(1'b0, 11'h000, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 11'h123, 32'h0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      reset_abort();
      issue(1'b0, 11'h3AA, 32'h0, 1'b0, 1'b0);

      if (VER) begin
         corrupt = 1'b1;
         issue(1'b1, 11'h0A5, 32'hA5A5A5A5, 1'b0, 1'b0);
         corrupt = 1'b0;
         issue(1'b1, 11'h0A5, 32'hA5A5A5A5, 1'b0, 1'b0);
         issue(1'b0, 11'h0A5, 32'h0, 1'b0, 1'b0);
      end

      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom);
         case ($urandom_range(0, 5))
            0:       a = 11'h000;
            1:       a = 11'h7FF;
            2:       a = 11'h005;
            default: a = 11'($urandom);
         endcase
         keep   = (i < 59) && ($urandom_range(0, 3) == 0);
         glitch = !keep && ($urandom_range(0, 3) == 0);
         issue(wr, a, $urandom, keep, glitch);
         if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
